// File: rtl/monitor_pkg.sv
// Shared types for the memory-write monitor: FSM state encoding and the
// helper that sizes the match counter.
package monitor_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      PASS    = 3'd2,
      FAIL    = 3'd3,
      TIMEOUT = 3'd4
   } state_t;

   function automatic int matchCntWidth(input int numChecks);
      return $clog2(numChecks + 1);
   endfunction

endpackage

// File: rtl/write_matcher.sv
// Combinational classifier for one processor write against the expected-write
// table: reports which entry it completes, a data mismatch, or that it is ignored.
module write_matcher #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int NUM_CHECKS = 4,
   parameter int IDX_W      = 3
) (
   input  logic [NUM_CHECKS*ADDR_W-1:0] expAddr,
   input  logic [NUM_CHECKS*DATA_W-1:0] expData,
   input  logic [NUM_CHECKS-1:0]        hitMask,
   input  logic [IDX_W-1:0]             index,
   input  logic                         ordered,
   input  logic                         wrValid,
   input  logic [ADDR_W-1:0]            wrAddr,
   input  logic [DATA_W-1:0]            wrData,
   output logic [NUM_CHECKS-1:0]        hit,
   output logic                         mismatch,
   output logic                         ignore
);

   logic found;
   logic hitAddrSeen;
   logic hitDataOk;

   always_comb begin
      hit         = '0;
      mismatch    = 1'b0;
      found       = 1'b0;
      hitAddrSeen = 1'b0;
      hitDataOk   = 1'b0;
      if (wrValid) begin
         if (ordered) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
               if (IDX_W'(i) == index && expAddr[i*ADDR_W +: ADDR_W] == wrAddr) begin
                  if (expData[i*DATA_W +: DATA_W] == wrData) hit[i] = 1'b1;
                  else                                       mismatch = 1'b1;
               end
            end
         end else begin
            // The lowest-index unhit entry with this address is the one the write targets.
            for (int i = 0; i < NUM_CHECKS; i++) begin
               if (!found && !hitMask[i] && expAddr[i*ADDR_W +: ADDR_W] == wrAddr) begin
                  found = 1'b1;
                  if (expData[i*DATA_W +: DATA_W] == wrData) hit[i] = 1'b1;
                  else                                       mismatch = 1'b1;
               end
            end
            for (int i = 0; i < NUM_CHECKS; i++) begin
               if (hitMask[i] && expAddr[i*ADDR_W +: ADDR_W] == wrAddr) begin
                  hitAddrSeen = 1'b1;
                  if (expData[i*DATA_W +: DATA_W] == wrData) hitDataOk = 1'b1;
               end
            end
            // A committed location overwritten with different data is corruption.
            if (!found && hitAddrSeen && !hitDataOk) mismatch = 1'b1;
         end
      end
      ignore = ~mismatch & ~(|hit);
   end

endmodule

// File: rtl/mem_write_monitor.sv
// Watches the processor memory-write port against a table of expected writes
// and reports a registered PASS / FAIL / TIMEOUT verdict.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for start
//   RUN     | counting cycles, checking writes against the table
//   PASS    | every table entry matched (sticky)
//   FAIL    | a write hit a table address with wrong data (sticky)
//   TIMEOUT | watchdog expired before completion (sticky)
module mem_write_monitor
   import monitor_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int NUM_CHECKS     = 4,
   parameter int ORDERED        = 1,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic                                  MemWriteM,
   input  logic [ADDR_W-1:0]                     DataAdrM,
   input  logic [DATA_W-1:0]                     WriteDataM,
   input  logic [NUM_CHECKS*ADDR_W-1:0]          exp_addr,
   input  logic [NUM_CHECKS*DATA_W-1:0]          exp_data,
   output logic                                  done,
   output logic                                  pass,
   output logic                                  fail,
   output logic                                  timeout,
   output logic [matchCntWidth(NUM_CHECKS)-1:0]  match_cnt,
   output logic [CNT_W-1:0]                      cycle_cnt,
   output logic [ADDR_W-1:0]                     fail_addr,
   output logic [DATA_W-1:0]                     fail_data
);

   localparam int MW = matchCntWidth(NUM_CHECKS);

   state_t                 state, stateNext;
   logic [NUM_CHECKS-1:0]  hitMask, hitMaskNext, hit;
   logic [MW-1:0]          matchNext;
   logic [CNT_W-1:0]       cycleNext;
   logic [ADDR_W-1:0]      failAddrNext;
   logic [DATA_W-1:0]      failDataNext;
   logic                   mismatch, ignore;

   write_matcher #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .NUM_CHECKS (NUM_CHECKS),
      .IDX_W      (MW)
   ) u_matcher (
      .expAddr  (exp_addr),
      .expData  (exp_data),
      .hitMask  (hitMask),
      .index    (match_cnt),
      .ordered  (ORDERED != 0),
      .wrValid  (MemWriteM),
      .wrAddr   (DataAdrM),
      .wrData   (WriteDataM),
      .hit      (hit),
      .mismatch (mismatch),
      .ignore   (ignore)
   );

   always_comb begin
      stateNext    = state;
      hitMaskNext  = hitMask;
      matchNext    = match_cnt;
      cycleNext    = cycle_cnt;
      failAddrNext = fail_addr;
      failDataNext = fail_data;
      if (start) begin
         stateNext    = RUN;
         hitMaskNext  = '0;
         matchNext    = '0;
         cycleNext    = '0;
         failAddrNext = '0;
         failDataNext = '0;
      end else if (state == RUN) begin
         if (mismatch) begin
            stateNext    = FAIL;
            failAddrNext = DataAdrM;
            failDataNext = WriteDataM;
            cycleNext    = cycle_cnt + 1'b1;
         end else begin
            if (!ignore) begin
               matchNext   = match_cnt + 1'b1;
               hitMaskNext = hitMask | hit;
            end
            if (!ignore && match_cnt == MW'(NUM_CHECKS - 1)) begin
               stateNext = PASS;
               cycleNext = cycle_cnt + 1'b1;
            end else if (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // The watchdog edge leaves cycle_cnt at its limit value.
               stateNext = TIMEOUT;
            end else begin
               cycleNext = cycle_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         hitMask   <= '0;
         match_cnt <= '0;
         cycle_cnt <= '0;
         fail_addr <= '0;
         fail_data <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= stateNext;
         hitMask   <= hitMaskNext;
         match_cnt <= matchNext;
         cycle_cnt <= cycleNext;
         fail_addr <= failAddrNext;
         fail_data <= failDataNext;
         done      <= (stateNext == PASS) || (stateNext == FAIL) || (stateNext == TIMEOUT);
         pass      <= (stateNext == PASS);
         fail      <= (stateNext == FAIL);
         timeout   <= (stateNext == TIMEOUT);
      end
   end

endmodule

// File: tb/tb_mem_write_monitor.sv
// Bench for mem_write_monitor: an ordered and an unordered instance share one
// stimulus stream and are compared every cycle against a per-mode reference model.
module tb_mem_write_monitor;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NC = 2;
   localparam int T  = 10;
   localparam int CW = 8;
   localparam int MW = 2;
   localparam int VW = 4 + MW + CW + AW + DW;

   localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3, M_TO = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic MemWriteM = 1'b0;
   logic [AW-1:0] DataAdrM = '0;
   logic [DW-1:0] WriteDataM = '0;
   logic [AW-1:0] ea [NC];
   logic [DW-1:0] ed [NC];
   logic [NC*AW-1:0] exp_addr;
   logic [NC*DW-1:0] exp_data;

   logic doneO, passO, failO, toO, doneU, passU, failU, toU;
   logic [MW-1:0] mcO, mcU;
   logic [CW-1:0] ccO, ccU;
   logic [AW-1:0] faO, faU;
   logic [DW-1:0] fdO, fdU;

   assign exp_addr = {ea[1], ea[0]};
   assign exp_data = {ed[1], ed[0]};

   always #5 clk = ~clk;

   mem_write_monitor #(.ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NC), .ORDERED(1),
                       .TIMEOUT_CYCLES(T), .CNT_W(CW)) dutO (
      .clk(clk), .reset(reset), .start(start), .MemWriteM(MemWriteM),
      .DataAdrM(DataAdrM), .WriteDataM(WriteDataM), .exp_addr(exp_addr), .exp_data(exp_data),
      .done(doneO), .pass(passO), .fail(failO), .timeout(toO), .match_cnt(mcO),
      .cycle_cnt(ccO), .fail_addr(faO), .fail_data(fdO));

   mem_write_monitor #(.ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NC), .ORDERED(0),
                       .TIMEOUT_CYCLES(T), .CNT_W(CW)) dutU (
      .clk(clk), .reset(reset), .start(start), .MemWriteM(MemWriteM),
      .DataAdrM(DataAdrM), .WriteDataM(WriteDataM), .exp_addr(exp_addr), .exp_data(exp_data),
      .done(doneU), .pass(passU), .fail(failU), .timeout(toU), .match_cnt(mcU),
      .cycle_cnt(ccU), .fail_addr(faU), .fail_data(fdU));

   int tests = 0;
   int failures = 0;

   // Reference model, index 0 = ordered, 1 = unordered.
   int          mSt  [2];
   int          mCnt [2];
   int          mCyc [2];
   bit          mHit [2][NC];
   logic [31:0] mFa  [2];
   logic [31:0] mFd  [2];

   function automatic void modelReset();
      for (int m = 0; m < 2; m++) begin
         mSt[m] = M_IDLE; mCnt[m] = 0; mCyc[m] = 0; mFa[m] = '0; mFd[m] = '0;
         for (int j = 0; j < NC; j++) mHit[m][j] = 1'b0;
      end
   endfunction

   function automatic void modelEdge(input bit st, input bit we,
                                     input logic [31:0] a, input logic [31:0] d);
      for (int m = 0; m < 2; m++) begin
         bit bad, matched, seen, ok;
         int tgt;
         if (st) begin
            mSt[m] = M_RUN; mCnt[m] = 0; mCyc[m] = 0; mFa[m] = '0; mFd[m] = '0;
            for (int j = 0; j < NC; j++) mHit[m][j] = 1'b0;
            continue;
         end
         if (mSt[m] != M_RUN) continue;
         bad = 0; matched = 0;
         if (we) begin
            if (m == 0) begin
               if (a == ea[mCnt[m]]) begin
                  if (d == ed[mCnt[m]]) matched = 1; else bad = 1;
               end
            end else begin
               tgt = -1;
               for (int j = 0; j < NC; j++)
                  if (tgt < 0 && !mHit[m][j] && ea[j] == a) tgt = j;
               if (tgt >= 0) begin
                  if (ed[tgt] == d) begin matched = 1; mHit[m][tgt] = 1'b1; end
                  else bad = 1;
               end else begin
                  seen = 0; ok = 0;
                  for (int j = 0; j < NC; j++)
                     if (mHit[m][j] && ea[j] == a) begin seen = 1; if (ed[j] == d) ok = 1; end
                  if (seen && !ok) bad = 1;
               end
            end
         end
         if (bad) begin
            mSt[m] = M_FAIL; mFa[m] = a; mFd[m] = d; mCyc[m]++;
         end else begin
            if (matched) mCnt[m]++;
            if (mCnt[m] == NC) begin mSt[m] = M_PASS; mCyc[m]++; end
            else if (mCyc[m] == T - 1) mSt[m] = M_TO;
            else mCyc[m]++;
         end
      end
   endfunction

   function automatic logic [VW-1:0] expVec(input int m);
      logic isDone;
      isDone = (mSt[m] == M_PASS) || (mSt[m] == M_FAIL) || (mSt[m] == M_TO);
      return {isDone, mSt[m] == M_PASS, mSt[m] == M_FAIL, mSt[m] == M_TO,
              MW'(mCnt[m]), CW'(mCyc[m]), mFa[m], mFd[m]};
   endfunction

   task automatic checkAll(input string tag);
      logic [VW-1:0] obsO, obsU, eO, eU;
      obsO = {doneO, passO, failO, toO, mcO, ccO, faO, fdO};
      obsU = {doneU, passU, failU, toU, mcU, ccU, faU, fdU};
      eO = expVec(0);
      eU = expVec(1);
      tests++;
      assert (obsO === eO) else begin
         failures++;
         $error("FAIL %s ordered: observed %h expected %h", tag, obsO, eO);
      end
      tests++;
      assert (obsU === eU) else begin
         failures++;
         $error("FAIL %s unordered: observed %h expected %h", tag, obsU, eU);
      end
   endtask

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic step(input bit st, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
      start = st; MemWriteM = we; DataAdrM = a; WriteDataM = d;
      @(posedge clk);
      modelEdge(st, we, a, d);
      #1;
      start = 1'b0; MemWriteM = 1'b0;
      checkAll(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, tag);
   endtask

   initial begin
      ea[0] = 100; ed[0] = 7; ea[1] = 104; ed[1] = 9;
      modelReset();
      #2;
      checkAll("reset");
      reset = 1'b1;

      // ordered and unordered pass, writes presented at cycle_cnt 3 and 6
      step(1, 0, 0, 0, "t1_start");
      idle(3, "t1_idle");
      step(0, 1, 100, 7, "t1_w0");
      checkVal("t1_match1", 32'(mcO), 1);
      idle(2, "t1_idle");
      step(0, 1, 104, 9, "t1_w1");
      checkVal("t1_passO", 32'(passO), 1);
      checkVal("t1_doneO", 32'(doneO), 1);
      checkVal("t1_cycleO", 32'(ccO), 7);
      idle(2, "t1_frozen");
      checkVal("t1_cycle_frozen", 32'(ccO), 7);

      // bad data at the second entry
      step(1, 0, 0, 0, "t2_start");
      step(0, 1, 100, 7, "t2_w0");
      step(0, 1, 104, 5, "t2_w1");
      checkVal("t2_failO", 32'(failO), 1);
      checkVal("t2_faddrO", faO, 104);
      checkVal("t2_fdataO", fdO, 5);
      checkVal("t2_matchO", 32'(mcO), 1);
      checkVal("t2_failU", 32'(failU), 1);

      // out-of-order sequence with an unrelated write
      step(1, 0, 0, 0, "t3_start");
      step(0, 1, 104, 9, "t3_w0");
      step(0, 1, 80, 3, "t3_w1");
      step(0, 1, 100, 7, "t3_w2");
      checkVal("t3_passU", 32'(passU), 1);
      checkVal("t3_matchO", 32'(mcO), 1);
      checkVal("t3_passO", 32'(passO), 0);

      // watchdog with no writes
      step(1, 0, 0, 0, "t4_start");
      idle(9, "t4_idle");
      checkVal("t4_not_yet", 32'(toO), 0);
      step(0, 0, 0, 0, "t4_edge");
      checkVal("t4_timeout", 32'(toO), 1);
      checkVal("t4_cycle", 32'(ccO), 9);

      // completing match on the watchdog edge wins
      step(1, 0, 0, 0, "t5_start");
      step(0, 1, 100, 7, "t5_w0");
      idle(8, "t5_idle");
      step(0, 1, 104, 9, "t5_w1");
      checkVal("t5_passU", 32'(passU), 1);
      checkVal("t5_timeoutU", 32'(toU), 0);

      // mismatch on the watchdog edge wins
      step(1, 0, 0, 0, "t6_start");
      idle(9, "t6_idle");
      step(0, 1, 100, 5, "t6_bad");
      checkVal("t6_failO", 32'(failO), 1);
      checkVal("t6_timeoutO", 32'(toO), 0);

      // asynchronous reset mid-run, then a fresh run
      step(1, 0, 0, 0, "t7_start");
      step(0, 1, 100, 7, "t7_w0");
      @(posedge clk);
      modelEdge(0, 0, 0, 0);
      #3;
      reset = 1'b0;
      modelReset();
      #1;
      checkAll("t7_async_reset");
      checkVal("t7_match_cleared", 32'(mcU), 0);
      #2;
      reset = 1'b1;
      step(1, 0, 0, 0, "t7_restart");
      step(0, 1, 100, 7, "t7_w0b");
      checkVal("t7_rematch", 32'(mcO), 1);

      // randomized runs with small address/data pools to force collisions
      for (int r = 0; r < 40; r++) begin
         for (int j = 0; j < NC; j++) begin
            ea[j] = 100 + 4 * $urandom_range(0, 2);
            ed[j] = $urandom_range(0, 2);
         end
         step(1, 0, 0, 0, "rnd_start");
         for (int k = 0; k < 12; k++)
            step($urandom_range(0, 15) == 0, $urandom_range(0, 1),
                 100 + 4 * $urandom_range(0, 3), $urandom_range(0, 2), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/mem_write_monitor.md
Name: mem_write_monitor

Overview:
- Synthesizable, parametrised self-checking monitor for the pipelined processor's memory-write port (MemWriteM / DataAdrM / WriteDataM).
- Replaces the single hard-coded address check in the bench with a table of NUM_CHECKS expected (address, data) writes, checked in ordered or unordered mode, with a cycle watchdog.
- Sits beside `top` in benches, or on FPGA driving status LEDs.

Parameters:
- ADDR_W, 32, width of DataAdrM and of each expected address.
- DATA_W, 32, width of WriteDataM and of each expected data word.
- NUM_CHECKS, 4, number of expected writes in the table (>=1).
- ORDERED, 1, 1 = expected writes must arrive in table order; 0 = any order.
- TIMEOUT_CYCLES, 1000, RUN cycles allowed before TIMEOUT (>=2).
- CNT_W, 16, width of cycle_cnt; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: clear counters and enter RUN.
- MemWriteM  in  1  processor memory write strobe.
- DataAdrM  in  ADDR_W  write address.
- WriteDataM  in  DATA_W  write data.
- exp_addr  in  NUM_CHECKS*ADDR_W  expected addresses, entry i at [i*ADDR_W +: ADDR_W]; held stable during RUN.
- exp_data  in  NUM_CHECKS*DATA_W  expected data, same packing.
- done  out  1  high in PASS, FAIL or TIMEOUT.
- pass  out  1  high in PASS.
- fail  out  1  high in FAIL.
- timeout  out  1  high in TIMEOUT.
- match_cnt  out  $clog2(NUM_CHECKS+1)  number of expected writes matched so far.
- cycle_cnt  out  CNT_W  RUN cycles elapsed.
- fail_addr  out  ADDR_W  address of the offending write.
- fail_data  out  DATA_W  data of the offending write.

Behaviour:
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. All outputs are registered.
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; hit mask 0; index 0. Reset asserted mid-RUN aborts immediately with no verdict.
- IDLE: wait for start=1, then go to RUN next edge with cycle_cnt=0, match_cnt=0, hit mask cleared.
- start=1 in any state restarts (same as the IDLE->RUN transition). Terminal states are otherwise sticky.
- RUN sampling: each rising edge, cycle_cnt increments.
  - If MemWriteM=1, the write is evaluated against the table.
  - Writes with MemWriteM=0 are ignored.
  - Writes to addresses not in the table are ignored.
- ORDERED=1 (current entry k = match_cnt):
  - addr==exp_addr[k] and data==exp_data[k]: match_cnt increments.
  - addr==exp_addr[k] and data differs: FAIL.
  - Address equal to an already-matched earlier entry: ignored.
  - Address equal to a later entry: ignored.
- ORDERED=0:
  - A write hits the lowest-index unhit entry with equal address.
  - Equal data: set its hit bit; match_cnt increments.
  - Address equal to some unhit entry but data differs: FAIL.
  - Re-write of a hit-only address: matching data is ignored; differing data is FAIL (post-commit corruption).
- PASS when match_cnt reaches NUM_CHECKS. The transition happens on the same edge as the final match; pass is visible one cycle after the write is presented.
- TIMEOUT when cycle_cnt == TIMEOUT_CYCLES-1 at an edge without a completing match.
- Priority on the same edge: FAIL > PASS > TIMEOUT.
- On entering FAIL, fail_addr/fail_data capture DataAdrM/WriteDataM. They are 0 otherwise and held until restart or reset.
- cycle_cnt and match_cnt freeze in terminal states.
- Duplicate table entries in unordered mode are allowed; each needs its own write.

Decomposition:
- Shared package `monitor_pkg`: state enum (IDLE, RUN, PASS, FAIL, TIMEOUT) and a localparam function for the match_cnt width.
- One natural sub-module: `write_matcher`, combinational.
  - Inputs: table, hit mask, index, mode, write.
  - Outputs: hit (one-hot), mismatch, ignore.
  - The FSM and counters stay in mem_write_monitor.

Test Plan:
- ORDERED=1, NUM_CHECKS=2, table {(100,7),(104,9)}; start, then writes (100,7) at cycle 3 and (104,9) at cycle 6 -> match_cnt 1 then 2; pass=done=1 the cycle after the second write; cycle_cnt frozen at 7.
- Same table; write (100,7), then (104,5) -> fail=1, fail_addr=104, fail_data=5, match_cnt=1, pass=0.
- ORDERED=0, same table; writes (104,9), (80,3), (100,7) -> (80,3) ignored; pass after the third write. With ORDERED=1 the same sequence leaves match_cnt=1 (the 104 write is ignored, then 100 matches).
- TIMEOUT_CYCLES=10, no writes after start -> timeout=1 exactly 10 edges after start; cycle_cnt=9; pass=fail=0.
- Final matching write on the edge where cycle_cnt=TIMEOUT_CYCLES-1 -> pass=1, timeout=0. Rewrite to an already-hit address with wrong data on the same edge as a completing match (ORDERED=0, one cycle only) is not possible; instead, test a mismatch write at the timeout edge -> fail=1.
- reset driven low mid-RUN (asynchronous, between edges) -> all outputs 0 immediately. Then start -> fresh run; table re-matched from entry 0.
